cache_access_initiator: RTL and testbench
=========================================

Name: cache_access_initiator

Overview:
- CPU-side initiator for the cache_memory_lru access port (addr, data_in, we, re → data_out, hit).
- Accepts load/store commands through a valid/ready interface and converts each one into a single-cycle we or re pulse. Drives the cache address and write data with that pulse.
- Captures data_out and hit after a fixed latency and returns one response per command through a valid/ready interface.
- Keeps read hit/miss statistics. It replaces hand-written bench tasks in system-level use.

Parameters:
- ADDR_W, 32, width of command and cache address.
- DATA_W, 32, width of write/read data.
- RSP_LATENCY, 1, number of clock edges from the edge where the cache samples we/re to the edge where data_out/hit are valid (range 1..7).
- GAP_CYCLES, 1, idle cycles driven to the cache after each response is accepted (range 0..15).
- CHECK_ALIGN, 1, when 1, commands with addr[1:0]!=0 are rejected without a cache access.
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  initiator can accept a command
- cmd_write  input  1  1=store, 0=load
- cmd_addr  input  ADDR_W  byte address
- cmd_wdata  input  DATA_W  store data
- cache_addr  output  ADDR_W  to cache addr
- cache_data_in  output  DATA_W  to cache data_in
- cache_we  output  1  to cache we
- cache_re  output  1  to cache re
- cache_data_out  input  DATA_W  from cache data_out
- cache_hit  input  1  from cache hit
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_write  output  1  echo of cmd_write
- rsp_rdata  output  DATA_W  captured read data (0 for stores)
- rsp_hit  output  1  captured cache_hit
- rsp_err  output  1  misaligned command rejected
- hit_count  output  CNT_W  read hits since reset
- miss_count  output  CNT_W  read misses since reset

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE; the latched command is discarded.
  - All outputs go to 0 except cmd_ready, which goes to 1.
  - Counters clear to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - cmd_ready=1. The handshake is cmd_valid&cmd_ready at edge T; the command (write, addr, wdata) is latched at T.
  - Aligned command, or CHECK_ALIGN=0: go to ISSUE.
  - Misaligned command with CHECK_ALIGN=1: go to RESP with rsp_err=1, rsp_rdata=0, rsp_hit=0, and no cache pulse.
- ISSUE (exactly one cycle, T..T+1):
  - cache_addr = latched addr.
  - Store: cache_we=1, cache_data_in = wdata.
  - Load: cache_re=1, cache_data_in = 0.
  - The cache samples the pulse at edge T+1. Go to WAIT.
- WAIT:
  - cache_we=cache_re=0; cache_addr is held at the latched addr.
  - A 3-bit counter counts edges. At edge T+1+RSP_LATENCY, capture: rsp_rdata = cache_data_out for loads and 0 for stores; rsp_hit = cache_hit.
  - At the capture edge, go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* outputs are stable until the edge where rsp_ready=1.
  - That edge is the handshake. Go to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - rsp_valid is never withdrawn without a handshake.
- GAP:
  - cache_addr=0, cache_data_in=0, we=re=0 for GAP_CYCLES cycles, then IDLE.
  - cmd_ready is 0 in every state except IDLE. No command overlap; at most one outstanding access.
- Throughput: with rsp_ready tied high, L=RSP_LATENCY and G=GAP_CYCLES, a new command is accepted every L+3+G cycles. The +3 is one cycle each for IDLE, ISSUE and RESP.
- Minimum latency: rsp_valid first high after edge T+1+L (T+2 for L=1).
- Counters:
  - They update at the capture edge, for loads only: hit_count+1 if cache_hit=1, else miss_count+1.
  - Both saturate at all-ones; no wrap.
  - Stores and rejected commands do not count.
- cache_we and cache_re are never both 1, and each is high for at most one cycle per command.
- A cmd_valid arriving while not in IDLE is ignored until IDLE; the upstream holds it stable.

Test Plan:
1. Store/load round trip:
   - Stimulus: store 0x00000000=0xAAAAAAAA, then load 0x00000000, with a cache model of RSP_LATENCY=1.
   - Response: cache_we high exactly one cycle with cache_data_in=0xAAAAAAAA. The load response has rsp_rdata=0xAAAAAAAA, rsp_hit=1, rsp_valid two edges after the handshake, and hit_count=1.
2. Four-way fill then eviction:
   - Stimulus: stores to 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14, then loads of 0x10, 0x14, 0x00, 0x04.
   - Response: rsp_rdata matches the model's data_out on every load. Counters equal the model's hit/miss tally.
3. Misaligned command:
   - Stimulus: load 0x00000002 with CHECK_ALIGN=1.
   - Response: no cache_re pulse. rsp_err=1, rsp_rdata=0, and the counters are unchanged.
4. Response backpressure:
   - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
   - Response: rsp_* stable and cmd_ready=0 throughout. The next cache pulse starts no earlier than GAP_CYCLES+2 edges after the rsp handshake.
5. Reset mid-operation:
   - Stimulus: assert reset during WAIT, off a clock edge.
   - Response: outputs clear immediately, no rsp_valid appears, and after release cmd_ready=1.
6. Counter saturation:
   - Stimulus: CNT_W=4 with 20 read hits.
   - Response: hit_count stops at 15.

Source files
------------

// File: rtl/cache_access_initiator_if.sv
// Bundle of the command, cache-port and response signals of cache_access_initiator.
// The master modport is the initiator's view; the slave modport is the view of
// whatever surrounds it (command source, cache, response consumer).
interface cache_access_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_data_in;
    logic              cache_we;
    logic              cache_re;
    logic [DATA_W-1:0] cache_data_out;
    logic              cache_hit;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_hit;
    logic              rsp_err;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cache_data_out, cache_hit, rsp_ready,
        output cmd_ready, cache_addr, cache_data_in, cache_we, cache_re,
        output rsp_valid, rsp_write, rsp_rdata, rsp_hit, rsp_err,
        output hit_count, miss_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cache_data_out, cache_hit, rsp_ready,
        input  cmd_ready, cache_addr, cache_data_in, cache_we, cache_re,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_hit, rsp_err,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_access_initiator.sv
// CPU-side initiator for the cache access port: turns each accepted load/store
// into a single we/re pulse, captures data_out/hit after RSP_LATENCY edges and
// returns one response per command. Keeps saturating read hit/miss counters.
module cache_access_initiator #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_LATENCY = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int CHECK_ALIGN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    cache_access_initiator_if.master   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_lat_cnt;
    logic [3:0]        r_gap_cnt;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_hit;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;

    logic w_misaligned;
    logic w_capture;
    logic w_issue;

    assign w_misaligned = (CHECK_ALIGN != 0) && (bus.cmd_addr[1:0] != 2'b00);
    // r_lat_cnt holds the number of edges seen since the cache sampled the pulse
    assign w_capture    = (r_state == S_WAIT) && (r_lat_cnt == 3'(RSP_LATENCY));
    assign w_issue      = (r_state == S_ISSUE);

    assign bus.cmd_ready     = (r_state == S_IDLE);
    assign bus.cache_we      = w_issue && r_write;
    assign bus.cache_re      = w_issue && !r_write;
    assign bus.cache_addr    = (w_issue || r_state == S_WAIT) ? r_addr : '0;
    assign bus.cache_data_in = (w_issue && r_write) ? r_wdata : '0;
    assign bus.rsp_valid     = (r_state == S_RESP);
    assign bus.rsp_write     = r_write;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_hit       = r_rsp_hit;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.hit_count     = r_hit_count;
    assign bus.miss_count    = r_miss_count;

    // Command sequencing: accept, pulse, wait for cache latency, respond, idle gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lat_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write <= bus.cmd_write;
                        r_addr  <= bus.cmd_addr;
                        r_wdata <= bus.cmd_wdata;
                        if (w_misaligned) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_hit   <= 1'b0;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_lat_cnt <= 3'd1;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_rsp_rdata <= r_write ? '0 : bus.cache_data_out;
                        r_rsp_hit   <= bus.cache_hit;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= 4'd1;
                            r_state   <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 4'(GAP_CYCLES)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating read hit/miss statistics, updated at the capture edge of loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_capture && !r_write) begin
            if (bus.cache_hit) begin
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
            end else begin
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cache_access_initiator.sv
// Self-checking bench for cache_access_initiator: a 4-entry LRU cache stand-in
// with a fixed response latency, randomized load/store traffic and backpressure,
// mid-operation reset and counter saturation.
module tb_cache_access_initiator;
    localparam int LAT = 1;
    localparam int GAP = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_access_initiator_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW)) bus ();

    cache_access_initiator #(
        .ADDR_W(32), .DATA_W(32), .RSP_LATENCY(LAT), .GAP_CYCLES(GAP),
        .CHECK_ALIGN(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- cache stand-in: 4-entry fully associative LRU ----------------
    logic [31:0] lru[$];
    logic [31:0] mem[logic [31:0]];

    function automatic void cache_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                         output logic [31:0] q, output logic h);
        int idx[$];
        idx = lru.find_first_index(x) with (x == a);
        h = (idx.size() != 0);
        if (h) lru.delete(idx[0]);
        else if (lru.size() == 4) void'(lru.pop_front());
        lru.push_back(a);
        if (wr) mem[a] = d;
        q = mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    int          both_hi = 0;
    logic        pulse_we;
    logic [31:0] pulse_addr, pulse_data;
    logic [31:0] env_q;
    logic        env_h;
    logic [31:0] pd[LAT];
    logic        ph[LAT];
    logic        pv[LAT];

    // Cache behaviour: sample we/re at the edge, present data_out/hit for exactly
    // the cycle ending at the capture edge, junk at all other times.
    always @(posedge clk) begin
        logic [31:0] q;
        logic h;
        cyc = cyc + 1;
        if (bus.cache_we && bus.cache_re) both_hi++;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1]; pd[i] = pd[i-1]; ph[i] = ph[i-1];
        end
        pv[0] = 1'b0;
        if (bus.cache_we || bus.cache_re) begin
            pulse_cnt++;
            pulse_cyc  = cyc;
            pulse_we   = bus.cache_we;
            pulse_addr = bus.cache_addr;
            pulse_data = bus.cache_data_in;
            cache_access(bus.cache_we, bus.cache_addr, bus.cache_data_in, q, h);
            env_q = q; env_h = h;
            pv[0] = 1'b1; pd[0] = q; ph[0] = h;
        end
        bus.cache_data_out <= pv[LAT-1] ? pd[LAT-1] : $urandom;
        bus.cache_hit      <= pv[LAT-1] ? ph[LAT-1] : 1'($urandom_range(0, 1));
    end

    // ---------------- reference statistics ----------------
    int ref_hits = 0;
    int ref_miss = 0;
    int sat_max = (1 << CW) - 1;

    // One full command: handshake, pulse/latency/response checks, backpressure,
    // response handshake, idle gap.
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input int bp);
        int n, base, bad;
        bit mis;
        logic [31:0] exp_d, snap_d;
        logic exp_h, snap_h, snap_e, snap_w;
        mis = (a[1:0] != 2'b00);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.cmd_ready) begin check_val("cmd_ready_timeout", 0, 1); return; end
        base = pulse_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom); bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check_val("rsp_latency", n, mis ? 0 : 1 + LAT);
        check_val("pulse_count", pulse_cnt - base, mis ? 0 : 1);
        if (mis) begin
            exp_d = 32'h0; exp_h = 1'b0;
        end else begin
            check_val("pulse_cycle", pulse_cyc - cyc, 0 - LAT);
            check_val("pulse_kind", pulse_we, wr);
            check_val("pulse_addr", pulse_addr, a);
            check_val("pulse_wdata", pulse_data, wr ? d : 32'h0);
            exp_d = wr ? 32'h0 : env_q;
            exp_h = env_h;
            if (!wr) begin
                if (exp_h) ref_hits = (ref_hits < sat_max) ? ref_hits + 1 : ref_hits;
                else       ref_miss = (ref_miss < sat_max) ? ref_miss + 1 : ref_miss;
            end
        end
        check_val("rsp_write", bus.rsp_write, wr);
        check_val("rsp_rdata", bus.rsp_rdata, exp_d);
        check_val("rsp_hit", bus.rsp_hit, exp_h);
        check_val("rsp_err", bus.rsp_err, mis);
        snap_d = bus.rsp_rdata; snap_h = bus.rsp_hit; snap_e = bus.rsp_err; snap_w = bus.rsp_write;
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_rdata !== snap_d || bus.rsp_hit !== snap_h ||
                bus.rsp_err !== snap_e || bus.rsp_write !== snap_w) bad++;
        end
        check_val("rsp_hold_stable", bad, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_val("rsp_after_hs", bus.rsp_valid, 0);
        check_val("hit_count", bus.hit_count, ref_hits);
        check_val("miss_count", bus.miss_count, ref_miss);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        check_val("gap_len", n, GAP);
    endtask

    logic [31:0] fill_addr[10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h10, 32'h14, 32'h00, 32'h04};

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        #1;
        check_val("reset_cmd_ready", bus.cmd_ready, 1);
        check_val("reset_rsp_valid", bus.rsp_valid, 0);
        check_val("reset_hit_count", bus.hit_count, 0);
        check_val("reset_pulse", bus.cache_we | bus.cache_re, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // store/load round trip
        do_cmd(1'b1, 32'h0, 32'hAAAA_AAAA, 0);
        do_cmd(1'b0, 32'h0, 32'h0, 0);
        check_val("roundtrip_hits", bus.hit_count, 1);

        // fill four ways, evict, reload
        for (int i = 0; i < 10; i++)
            do_cmd(i < 6, fill_addr[i], 32'h1000 + i, 0);

        // misaligned load, then explicit backpressure
        do_cmd(1'b0, 32'h2, 32'h0, 0);
        do_cmd(1'b0, 32'h14, 32'h0, 5);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_cmd(1'($urandom), a, $urandom, $urandom_range(0, 5));
        end

        // reset while waiting for the cache response
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h10;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_val("midrst_rsp_valid", bus.rsp_valid, 0);
        check_val("midrst_cmd_ready", bus.cmd_ready, 1);
        check_val("midrst_cache_addr", bus.cache_addr, 0);
        check_val("midrst_miss_count", bus.miss_count, 0);
        ref_hits = 0; ref_miss = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        begin
            int seen = 0;
            int rdy_lo = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus.rsp_valid) seen++;
                if (!bus.cmd_ready) rdy_lo++;
            end
            check_val("midrst_no_rsp", seen, 0);
            check_val("midrst_ready_hold", rdy_lo, 0);
        end

        // counter saturation: prime one line, then 20 read hits
        do_cmd(1'b1, 32'h20, 32'h5A5A_0001, 0);
        for (int i = 0; i < 20; i++) do_cmd(1'b0, 32'h20, 32'h0, 0);
        check_val("hit_saturated", bus.hit_count, 15);
        check_val("we_re_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
